discretizador_multinivel: RTL and testbench
===========================================

# discretizador_multinivel

Parametrised successor to the fixed four-level sensor discretiser. It maps an N-bit sensor sample onto one of K categories. Thresholds are runtime-programmable, hysteresis suppresses chatter at level boundaries, and a persistence filter requires PERSIST consecutive agreeing samples before the category changes. It sits between the sensor acquisition path and the control FSM, which consumes `saida` together with the `valid`/`mudou` strobes.

## Interface
- `N`, 12: sample width in bits.
- `K`, 4: number of categories, 2..16. `CW = $clog2(K)` is derived and not overridable.
- `HYST`, 2: hysteresis margin in LSBs, 0..2^N-1. `HYST=0` disables hysteresis.
- `PERSIST`, 3: consecutive agreeing samples required to change category, 1..255.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `load`  in  1  sample strobe; `bits_in` is evaluated only when `load`=1.
- `bits_in`  in  N  unsigned sensor sample.
- `cfg_we`  in  1  threshold write enable.
- `cfg_idx`  in  4  threshold index, 0..K-2.
- `cfg_data`  in  N  threshold value.
- `saida`  out  CW  registered current category.
- `valid`  out  1  one-cycle pulse: a load was processed this cycle.
- `mudou`  out  1  one-cycle pulse: `saida` changed this cycle.

## Operation
- **Threshold bank:** K-1 registers `thr[i]`.
  - Reset value: `thr[i] = 8*(i+1)`, truncated to N bits.
  - A write with `cfg_idx > K-2` is ignored.
  - Thresholds are not checked for ordering. The counting rules below stay well-defined for any contents.
- **Category counts:** all compares are unsigned at N+1 bits, so there is no overflow.
  - `c_up` = number of i with `bits_in > thr[i] + HYST`.
  - `c_dn` = number of i with `bits_in + HYST > thr[i]`.
  - With ordered thresholds, `c_up <= c_dn`.
- **Candidate selection,** relative to current `s = saida`:
  - If `c_up > s`: candidate = `c_up`.
  - Else if `c_dn < s`: candidate = `c_dn`.
  - Else: candidate = `s`.
- **Persistence FSM:** registers `pend` (CW bits) and `cnt` (8 bits). All transitions happen only on `load`=1.
  - **IDLE**, candidate ≠ s: `pend` ← candidate, `cnt` ← 1, go to PEND.
    - If `PERSIST`=1, instead commit immediately and stay in IDLE.
  - **IDLE**, candidate = s: no change.
  - **PEND**, candidate = s: `cnt` ← 0, go to IDLE.
  - **PEND**, candidate ≠ s and ≠ `pend`: `pend` ← candidate, `cnt` ← 1. The count restarts.
  - **PEND**, candidate = `pend`: `cnt` ← `cnt`+1.
    - When the new count equals `PERSIST`: commit, `cnt` ← 0, go to IDLE.
  - **Commit:** `saida` ← `pend` (or candidate when `PERSIST`=1), and `mudou` ← 1.
- **Simultaneous events:**
  - `cfg_we` and `load` in the same cycle: the sample uses the old threshold; the new value applies from the next cycle. A write never alters `pend`/`cnt`.
  - `load`=0 cycles are ignored; persistence counts samples, not cycles.

## Timing
- **Reset values:** `saida`=0, `valid`=0, `mudou`=0, `cnt`=0, FSM=IDLE, thresholds at their defaults.
- **Reset mid-operation:** asynchronous assertion discards any pending count immediately.
- **Latency:** a load sampled at edge k updates `saida`, `valid` and `mudou` at edge k. They are visible in the cycle after edge k, matching the previous discretiser.
- `valid` = registered `load`, high exactly one cycle per load.
- `mudou` is high only in the cycle after a commit edge, and never while `valid`=0.
- `saida` holds between loads and changes by any amount in a single commit (e.g. 0→3).

## Test plan
All scenarios use defaults (N=12, K=4, HYST=2, PERSIST=3, thr=8/16/24).
- **Reset:** assert `reset` asynchronously -> `saida`=0, `valid`=0, `mudou`=0, thresholds read back via behaviour as 8/16/24.
- **Persistence:** from `saida`=0, load 20 three times -> `saida`=2 after the 3rd load only; `mudou` pulses once; `valid` pulses 3×.
- **Hysteresis:** with `saida`=2:
  - Load 17 ×5 -> `saida` stays 2 (`c_up`=1, `c_dn`=2).
  - Then load 14 ×3 -> `saida`=1 after the 3rd.
- **Interruption:** from 0, load 30, 30, 5, 30, 30, 30 -> no change until the 6th load, which gives `saida`=3. The 5 resets the count.
- **Config:**
  - Write `thr[2]`=100, then load 30 ×3 from 0 -> `saida`=2.
  - A write with `cfg_idx`=3 has no effect.
  - A write coincident with a load applies from the next load.
- **Reset mid-pend:** load 30 twice, assert `reset`, then load 30 once -> `saida`=0, `mudou` never asserted.

Source files
------------

// File: rtl/discretizador_multinivel.sv
// Multi-level sensor discretiser: programmable thresholds, hysteresis and a
// persistence filter that needs PERSIST agreeing samples before saida moves.
module discretizador_multinivel #(
  parameter int N       = 12,
  parameter int K       = 4,
  parameter int HYST    = 2,
  parameter int PERSIST = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [N-1:0]         bits_in,
  input  logic                 cfg_we,
  input  logic [3:0]           cfg_idx,
  input  logic [N-1:0]         cfg_data,
  output logic [$clog2(K)-1:0] saida,
  output logic                 valid,
  output logic                 mudou
);

  localparam int CW = $clog2(K);
  localparam logic [N:0] HV = (N+1)'(HYST);
  localparam logic [7:0] PV = 8'(PERSIST);

  typedef enum logic {IDLE, PEND} state_t;

  state_t        r_state, w_stateNext;
  logic [CW-1:0] r_saida, r_pend, w_pendNext, w_cand, w_cup, w_cdn, w_commitVal;
  logic [7:0]    r_cnt, w_cntNext, w_cntInc;
  logic          r_valid, r_mudou, w_commit;
  logic [N-1:0]  r_thr [K-1];

  // Threshold bank; out-of-range indices simply match no register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < K-1; i++) r_thr[i] <= N'(8*(i+1));
    end else begin
      for (int i = 0; i < K-1; i++)
        if (cfg_we && cfg_idx == 4'(i)) r_thr[i] <= cfg_data;
    end
  end

  // Compares are done at N+1 bits so threshold plus margin cannot wrap.
  always_comb begin
    w_cup = '0;
    w_cdn = '0;
    for (int i = 0; i < K-1; i++) begin
      if ({1'b0, bits_in} > {1'b0, r_thr[i]} + HV) w_cup = w_cup + CW'(1);
      if ({1'b0, bits_in} + HV > {1'b0, r_thr[i]}) w_cdn = w_cdn + CW'(1);
    end
    if (w_cup > r_saida)      w_cand = w_cup;
    else if (w_cdn < r_saida) w_cand = w_cdn;
    else                      w_cand = r_saida;
  end

  always_comb begin
    w_stateNext = r_state;
    w_pendNext  = r_pend;
    w_cntNext   = r_cnt;
    w_commit    = 1'b0;
    w_commitVal = r_pend;
    w_cntInc    = r_cnt + 8'd1;
    if (load) begin
      case (r_state)
        IDLE: begin
          if (w_cand != r_saida) begin
            if (PERSIST == 1) begin
              w_commit    = 1'b1;
              w_commitVal = w_cand;
            end else begin
              w_pendNext  = w_cand;
              w_cntNext   = 8'd1;
              w_stateNext = PEND;
            end
          end
        end
        PEND: begin
          if (w_cand == r_saida) begin
            w_cntNext   = 8'd0;
            w_stateNext = IDLE;
          end else if (w_cand != r_pend) begin
            w_pendNext = w_cand;
            w_cntNext  = 8'd1;
          end else if (w_cntInc == PV) begin
            w_commit    = 1'b1;
            w_commitVal = r_pend;
            w_cntNext   = 8'd0;
            w_stateNext = IDLE;
          end else begin
            w_cntNext = w_cntInc;
          end
        end
        default: w_stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_pend  <= '0;
      r_cnt   <= '0;
      r_saida <= '0;
      r_valid <= 1'b0;
      r_mudou <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_pend  <= w_pendNext;
      r_cnt   <= w_cntNext;
      r_valid <= load;
      r_mudou <= w_commit;
      if (w_commit) r_saida <= w_commitVal;
    end
  end

  assign saida = r_saida;
  assign valid = r_valid;
  assign mudou = r_mudou;

endmodule

// File: tb/tb_discretizador_multinivel.sv
// Bench for discretizador_multinivel: directed scenarios plus random traffic,
// all compared against an integer run-length model of the category filter.
module tb_discretizador_multinivel;

  localparam int N = 12;
  localparam int K = 4;
  localparam int HYST = 2;
  localparam int PERSIST = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          load = 1'b0;
  logic [N-1:0]  bits_in = '0;
  logic          cfg_we = 1'b0;
  logic [3:0]    cfg_idx = '0;
  logic [N-1:0]  cfg_data = '0;
  logic [1:0]    saida;
  logic          valid;
  logic          mudou;

  int total = 0;
  int bad = 0;

  // Reference model state: committed category and the current run of
  // identical candidates that differ from it.
  int mThr [K-1];
  int mSaida;
  int mRunVal;
  int mRunLen;
  int mValid;
  int mMudou;

  discretizador_multinivel #(.N(N), .K(K), .HYST(HYST), .PERSIST(PERSIST)) dut (
    .clk(clk), .reset(reset), .load(load), .bits_in(bits_in),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .saida(saida), .valid(valid), .mudou(mudou)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    if (observed != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < K-1; i++) mThr[i] = 8*(i+1);
    mSaida = 0;
    mRunVal = 0;
    mRunLen = 0;
    mValid = 0;
    mMudou = 0;
  endtask

  function automatic int modelCandidate(input int x);
    int up, dn;
    up = 0;
    dn = 0;
    for (int i = 0; i < K-1; i++) begin
      if (x > mThr[i] + HYST) up++;
      if (x + HYST > mThr[i]) dn++;
    end
    if (up > mSaida) return up;
    if (dn < mSaida) return dn;
    return mSaida;
  endfunction

  task automatic modelClock(input bit ld, input int x, input bit we, input int idx, input int data);
    int cand;
    mValid = ld;
    mMudou = 0;
    if (ld) begin
      cand = modelCandidate(x);
      if (cand == mSaida) mRunLen = 0;
      else if (mRunLen > 0 && cand == mRunVal) mRunLen++;
      else begin
        mRunVal = cand;
        mRunLen = 1;
      end
      if (mRunLen == PERSIST) begin
        mSaida = cand;
        mMudou = 1;
        mRunLen = 0;
      end
    end
    if (we && idx < K-1) mThr[idx] = data % (1 << N);
  endtask

  task automatic applyStimulus(input bit ld, input int x, input bit we, input int idx, input int data);
    @(negedge clk);
    load = ld;
    bits_in = N'(x);
    cfg_we = we;
    cfg_idx = 4'(idx);
    cfg_data = N'(data);
    @(posedge clk);
    modelClock(ld, x, we, idx, data);
    #1;
    checkOutput("saida", int'(saida), mSaida);
    checkOutput("valid", int'(valid), mValid);
    checkOutput("mudou", int'(mudou), mMudou);
  endtask

  task automatic loadN(input int x, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, x, 1'b0, 0, 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    load = 1'b0;
    cfg_we = 1'b0;
    #2 reset = 1'b1;
    #1;
    modelReset();
    checkOutput("rst_saida", int'(saida), 0);
    checkOutput("rst_valid", int'(valid), 0);
    checkOutput("rst_mudou", int'(mudou), 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    modelReset();
    doReset();

    // Persistence: three loads of 20 move 0 -> 2 on the third only.
    loadN(20, 2);
    checkOutput("persist_early", int'(saida), 0);
    loadN(20, 1);
    checkOutput("persist_saida", int'(saida), 2);
    checkOutput("persist_mudou", int'(mudou), 1);

    // Hysteresis around the 16 threshold.
    loadN(17, 5);
    checkOutput("hyst_hold", int'(saida), 2);
    loadN(14, 3);
    checkOutput("hyst_drop", int'(saida), 1);

    // Interruption: the 5 breaks the run.
    doReset();
    loadN(30, 2);
    loadN(5, 1);
    loadN(30, 2);
    checkOutput("interrupt_hold", int'(saida), 0);
    loadN(30, 1);
    checkOutput("interrupt_saida", int'(saida), 3);

    // Config: raised top threshold, ignored index 3, coincident write.
    doReset();
    applyStimulus(1'b0, 0, 1'b1, 2, 100);
    loadN(30, 3);
    checkOutput("cfg_thr2", int'(saida), 2);
    applyStimulus(1'b0, 0, 1'b1, 3, 0);
    loadN(20, 3);
    checkOutput("cfg_idx3", int'(saida), 2);
    applyStimulus(1'b1, 30, 1'b1, 2, 20);
    loadN(30, 2);
    checkOutput("cfg_coincident_hold", int'(saida), 2);
    loadN(30, 1);
    checkOutput("cfg_coincident_saida", int'(saida), 3);

    // Reset while a change is pending.
    doReset();
    loadN(30, 2);
    doReset();
    loadN(30, 1);
    checkOutput("midpend_saida", int'(saida), 0);
    checkOutput("midpend_mudou", int'(mudou), 0);

    // Random traffic near the thresholds, with writes and occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) doReset();
      else begin
        int x;
        x = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, (1 << N) - 1))
                                         : int'($urandom_range(0, 40));
        applyStimulus(1'($urandom_range(0, 3) != 0), x,
                      1'($urandom_range(0, 15) == 0),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 40)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
